// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter_pkg: shared types/constants for the data-memory arbiter  |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_grant2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_grant2: combinational two-way round-robin picker, one-hot grant    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module rr_grant2
  import dmem_arbiter_pkg::*;
(
  input  logic       req0,
  input  logic       req1,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req0 && req1) begin
      // On a tie the requester that was not served last wins.
      gnt[REQ_CPU] = last;
      gnt[REQ_DMA] = ~last;
    end else begin
      gnt[REQ_CPU] = req0;
      gnt[REQ_DMA] = req1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter: round-robin + bounded-lock arbiter for the 4Kx16 dmem   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MAX_BEATS = MAX_BURST[3:0];

  arb_state_t state, state_nx;
  logic       last, last_nx;
  logic [3:0] beat_cnt, beat_nx;
  logic [1:0] rr_gnt;
  logic [1:0] gnt;

  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= MAX_BEATS) ? MAX_BEATS : cnt + 4'd1;
  endfunction

  rr_grant2 u_rr (
    .req0 (req0),
    .req1 (req1),
    .last (last),
    .gnt  (rr_gnt)
  );

  // An owner keeps the memory until its burst budget is spent and the
  // other side is waiting; a released lock falls back to round-robin.
  always_comb begin
    gnt = rr_gnt;
    case (state)
      OWN0: begin
        if (req0) begin
          if (beat_cnt < MAX_BEATS) gnt = 2'b01;
          else if (req1)            gnt = 2'b10;
          else                      gnt = 2'b01;
        end
      end
      OWN1: begin
        if (req1) begin
          if (beat_cnt < MAX_BEATS) gnt = 2'b10;
          else if (req0)            gnt = 2'b01;
          else                      gnt = 2'b10;
        end
      end
      default: ;
    endcase
    if (rst) gnt = 2'b00;
  end

  assign gnt0 = gnt[REQ_CPU];
  assign gnt1 = gnt[REQ_DMA];

  always_comb begin
    state_nx = IDLE;
    last_nx  = last;
    beat_nx  = 4'd0;
    if (gnt[REQ_CPU]) begin
      last_nx = 1'b0;
      if (lock0) begin
        state_nx = OWN0;
        beat_nx  = (state == OWN0) ? sat_inc(beat_cnt) : 4'd1;
      end
    end else if (gnt[REQ_DMA]) begin
      last_nx = 1'b1;
      if (lock1) begin
        state_nx = OWN1;
        beat_nx  = (state == OWN1) ? sat_inc(beat_cnt) : 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      beat_cnt <= 4'd0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      beat_cnt <= beat_nx;
    end
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (gnt[REQ_CPU]) begin
      mem_rd   = ~we0;
      mem_wr   = we0;
      mem_addr = addr0;
      mem_wd   = wdata0;
    end else if (gnt[REQ_DMA]) begin
      mem_rd   = ~we1;
      mem_wr   = we1;
      mem_addr = addr1;
      mem_wd   = wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= gnt[REQ_CPU] & ~we0;
      rvalid1 <= gnt[REQ_DMA] & ~we1;
      if (gnt[REQ_CPU] && !we0) rdata0 <= mem_rdata;
      if (gnt[REQ_DMA] && !we1) rdata1 <= mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter: directed vector bench for dmem_arbiter               |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        req0, req1, we0, we1, lock0, lock1;
  logic [11:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [15:0] rdata0, rdata1;
  logic        mem_rd, mem_wr;
  logic [11:0] mem_addr;
  logic [15:0] mem_wd, mem_rdata;

  logic [15:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wd;

  typedef struct {
    logic        rst, req0, req1, we0, we1, lock0, lock1;
    logic [11:0] a0, a1;
    logic [15:0] d0, d1;
    logic [1:0]  eg;   // {gnt1, gnt0}
    logic        erd, ewr;
    logic [11:0] ea;
    logic [15:0] ewd;
    logic        erv0, erv1;
    logic [15:0] erdata0, erdata1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic q0, logic q1, logic w0, logic w1,
                              logic l0, logic l1, logic [11:0] a0, logic [11:0] a1,
                              logic [15:0] d0, logic [15:0] d1, logic [1:0] eg,
                              logic erd, logic ewr, logic [11:0] ea, logic [15:0] ewd,
                              logic erv0, logic erv1, logic [15:0] e0, logic [15:0] e1);
    vec_t v;
    v.rst = r; v.req0 = q0; v.req1 = q1; v.we0 = w0; v.we1 = w1;
    v.lock0 = l0; v.lock1 = l1; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.eg = eg; v.erd = erd; v.ewr = ewr; v.ea = ea; v.ewd = ewd;
    v.erv0 = erv0; v.erv1 = erv1; v.erdata0 = e0; v.erdata1 = e1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; req0 = v.req0; req1 = v.req1; we0 = v.we0; we1 = v.we1;
    lock0 = v.lock0; lock1 = v.lock1; addr0 = v.a0; addr1 = v.a1;
    wdata0 = v.d0; wdata1 = v.d1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    lock0 = 1'b0; lock1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] eseq [0:8];
    int k, nb, waited;
    logic g0done;

    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h010] = 16'h1234;
    for (int i = 0; i < 8; i++) mem[12'h100 + i] = 16'h1000 + 16'(i);

    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_outputs", {gnt1, gnt0, mem_rd, mem_wr, mem_addr, rvalid1, rvalid0, rdata0, rdata1},
        64'h0);
    @(posedge clk); #1;

    // single read, then reset
    vecs.push_back(mk(0,1,0,0,0,0,0,12'h010,0,0,0, 2'b01,1,0,12'h010,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,       2'b00,0,0,0,0,       1,0,16'h1234,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,       2'b00,0,0,0,0,       0,0,0,0));
    // both writing, alternating grants
    vecs.push_back(mk(0,1,1,1,1,0,0,12'h020,12'h021,16'hAAAA,16'hBBBB, 2'b01,0,1,12'h020,16'hAAAA, 0,0,0,0));
    vecs.push_back(mk(0,1,1,1,1,0,0,12'h020,12'h021,16'hAAAA,16'hBBBB, 2'b10,0,1,12'h021,16'hBBBB, 0,0,0,0));
    vecs.push_back(mk(0,1,1,1,1,0,0,12'h020,12'h021,16'hAAAA,16'hBBBB, 2'b01,0,1,12'h020,16'hAAAA, 0,0,0,0));
    vecs.push_back(mk(0,1,1,1,1,0,0,12'h020,12'h021,16'hAAAA,16'hBBBB, 2'b10,0,1,12'h021,16'hBBBB, 0,0,0,0));
    vecs.push_back(mk(0,0,0,1,1,1,1,12'h055,12'h066,16'hFFFF,16'hEEEE, 2'b00,0,0,0,0, 0,0,0,0));
    // write suppressed by reset, then read back original value
    vecs.push_back(mk(1,1,0,1,0,0,0,12'h030,0,16'h5555,0, 2'b00,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,0,0,12'h030,0,0,0,        2'b01,1,0,12'h030,0, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,              2'b00,0,0,0,0, 1,0,16'h0000,0));
    // simultaneous first reads after reset
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,              2'b00,0,0,0,0, 0,0,0,0));
    vecs.push_back(mk(0,1,1,0,0,0,0,12'h010,12'h100,0,0,  2'b01,1,0,12'h010,0, 0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,0,0,0,12'h100,0,0,        2'b10,1,0,12'h100,0, 1,0,16'h1234,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,              2'b00,0,0,0,0, 0,1,0,16'h1000));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i),
          {gnt1, gnt0, mem_rd, mem_wr, mem_addr, mem_wd, rvalid1, rvalid0},
          {vecs[i].eg, vecs[i].erd, vecs[i].ewr, vecs[i].ea, vecs[i].ewd, vecs[i].erv1, vecs[i].erv0});
      if (vecs[i].erv0) chk($sformatf("vec%0d_rdata0", i), rdata0, vecs[i].erdata0);
      if (vecs[i].erv1) chk($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].erdata1);
      @(posedge clk); #1;
    end

    chk("mem_020", mem[12'h020], 16'hAAAA);
    chk("mem_021", mem[12'h021], 16'hBBBB);
    chk("mem_030", mem[12'h030], 16'h0000);

    // locked DMA burst with the CPU waiting: forced yield after 4 beats
    do_reset();
    eseq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    k = 0; nb = 0; waited = 0; g0done = 1'b0;
    for (int c = 0; c < 9; c++) begin
      idle_inputs();
      req1 = 1'b1; lock1 = 1'b1; addr1 = 12'h100 + 12'(k);
      req0 = (c >= 1) && !g0done; addr0 = 12'h040;
      @(negedge clk);
      chk($sformatf("burst_gnt_c%0d", c), {gnt1, gnt0}, eseq[c]);
      if (c >= 1) begin
        chk($sformatf("burst_rv_c%0d", c), {rvalid1, rvalid0},
            {eseq[c-1] == 2'b10, eseq[c-1] == 2'b01});
        if (eseq[c-1] == 2'b10) chk($sformatf("burst_rd1_c%0d", c), rdata1, 16'h1000 + 16'(nb - 1));
        if (eseq[c-1] == 2'b01) chk("burst_rd0", rdata0, 16'h0000);
      end
      if (req0) waited++;
      if (gnt0) g0done = 1'b1;
      if (gnt1) k++;
      if (eseq[c] == 2'b10) nb++;
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    chk("burst_last_rv", {rvalid1, rvalid0}, 2'b10);
    chk("burst_last_rd1", rdata1, 16'h1007);
    chk("yield_wait_bound", {g0done, (waited <= 5)}, 2'b11);
    @(posedge clk); #1;

    // locked DMA burst with no competitor: beat counter saturates
    do_reset();
    for (int c = 0; c < 8; c++) begin
      idle_inputs();
      req1 = 1'b1; lock1 = 1'b1; addr1 = 12'h100 + 12'(c);
      @(negedge clk);
      chk($sformatf("solo_gnt_c%0d", c), {gnt1, gnt0}, 2'b10);
      @(posedge clk); #1;
    end
    idle_inputs();
    req1 = 1'b1; lock1 = 1'b1; addr1 = 12'h108;
    req0 = 1'b1; addr0 = 12'h010;
    @(negedge clk);
    chk("beat_sat", dut.beat_cnt, 4'd4);
    chk("sat_yield_gnt", {gnt1, gnt0}, 2'b01);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("sat_yield_rv", {rvalid1, rvalid0}, 2'b01);
    chk("sat_yield_rd0", rdata0, 16'h1234);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
